// File: rtl/bus_dev_fifo_bank.sv
// Per-device TX/RX FIFO bank for one shared-bus lane, with per-device overflow drop counters.
// Optional macro DEST_CHECK_EN: discard misrouted RX pushes and count them in misroute_cnt.
module bus_dev_fifo_bank #(
  parameter int unsigned drvrs     = 5,
  parameter int unsigned pckg_sz   = 16,
  parameter int unsigned depth     = 4,
  parameter logic [7:0]  broadcast = 8'b1000_1111
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [drvrs-1:0]           tx_wr,
  input  logic [drvrs*pckg_sz-1:0]   tx_data,
  output logic [drvrs-1:0]           tx_full,
  output logic [drvrs-1:0]           pndng,
  output logic [drvrs*pckg_sz-1:0]   D_pop,
  input  logic [drvrs-1:0]           pop,
  input  logic [drvrs-1:0]           push,
  input  logic [drvrs*pckg_sz-1:0]   D_push,
  input  logic [drvrs-1:0]           rx_rd,
  output logic [drvrs*pckg_sz-1:0]   rx_data,
  output logic [drvrs-1:0]           rx_empty,
  output logic [drvrs*8-1:0]         drop_cnt
`ifdef DEST_CHECK_EN
  ,
  output logic [drvrs*8-1:0]         misroute_cnt
`endif
);

  localparam int unsigned PW = $clog2(depth);
  localparam int unsigned CW = $clog2(depth + 1);

  for (genvar i = 0; i < drvrs; i++) begin : g_dev
    logic [pckg_sz-1:0] tx_mem [depth];
    logic [pckg_sz-1:0] rx_mem [depth];
    logic [PW-1:0]      tx_rp, tx_wp, rx_rp, rx_wp;
    logic [CW-1:0]      tx_cnt, rx_cnt;
    logic [7:0]         drops;
    logic [8:0]         drop_sum;
    logic [pckg_sz-1:0] tx_din, rx_din;
    logic               tx_full_i, tx_nemp, rx_full_i, rx_nemp;
    logic               tx_we, tx_re, tx_drop, rx_we, rx_re, rx_drop;
    logic               dst_ok;

    assign tx_din = tx_data[i*pckg_sz +: pckg_sz];
    assign rx_din = D_push[i*pckg_sz +: pckg_sz];

`ifdef DEST_CHECK_EN
    logic [7:0] dst;
    logic [7:0] mis;

    assign dst    = rx_din[pckg_sz-1 -: 8];
    assign dst_ok = (dst == 8'(i)) || (dst == broadcast);

    // Misrouted pushes are counted here and never reach the overflow counter.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        mis <= 8'h00;
      end else if (push[i] && !dst_ok && (mis != 8'hFF)) begin
        mis <= mis + 8'h01;
      end
    end

    assign misroute_cnt[i*8 +: 8] = mis;
`else
    assign dst_ok = 1'b1;
`endif

    // Full/empty decisions use the pre-edge occupancy.
    always_comb begin
      tx_full_i = (tx_cnt == CW'(depth));
      tx_nemp   = (tx_cnt != '0);
      rx_full_i = (rx_cnt == CW'(depth));
      rx_nemp   = (rx_cnt != '0);
      tx_we     = tx_wr[i] && !tx_full_i;
      tx_drop   = tx_wr[i] && tx_full_i;
      tx_re     = pop[i] && tx_nemp;
      rx_we     = push[i] && dst_ok && !rx_full_i;
      rx_drop   = push[i] && dst_ok && rx_full_i;
      rx_re     = rx_rd[i] && rx_nemp;
      drop_sum  = {1'b0, drops} + 9'(tx_drop) + 9'(rx_drop);
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        tx_rp  <= '0;
        tx_wp  <= '0;
        tx_cnt <= '0;
        rx_rp  <= '0;
        rx_wp  <= '0;
        rx_cnt <= '0;
        drops  <= 8'h00;
      end else begin
        if (tx_we) tx_wp <= tx_wp + PW'(1);
        if (tx_re) tx_rp <= tx_rp + PW'(1);
        if (rx_we) rx_wp <= rx_wp + PW'(1);
        if (rx_re) rx_rp <= rx_rp + PW'(1);
        tx_cnt <= tx_cnt + CW'(tx_we) - CW'(tx_re);
        rx_cnt <= rx_cnt + CW'(rx_we) - CW'(rx_re);
        drops  <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      end
    end

    // Storage needs no reset: heads are masked to zero while empty.
    always_ff @(posedge clk) begin
      if (tx_we) tx_mem[tx_wp] <= tx_din;
      if (rx_we) rx_mem[rx_wp] <= rx_din;
    end

    assign tx_full[i]                   = tx_full_i;
    assign pndng[i]                     = tx_nemp;
    assign rx_empty[i]                  = !rx_nemp;
    assign D_pop[i*pckg_sz +: pckg_sz]   = tx_nemp ? tx_mem[tx_rp] : '0;
    assign rx_data[i*pckg_sz +: pckg_sz] = rx_nemp ? rx_mem[rx_rp] : '0;
    assign drop_cnt[i*8 +: 8]           = drops;
  end

endmodule

// File: tb/tb_bus_dev_fifo_bank.sv
// Directed bench for bus_dev_fifo_bank: queue-based model checked every cycle plus literal spot checks.
module tb_bus_dev_fifo_bank;
  localparam int unsigned D  = 5;
  localparam int unsigned W  = 16;
  localparam int unsigned DP = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [D-1:0]   tx_wr, pop, push, rx_rd;
  logic [D*W-1:0] tx_data, D_push;
  logic [D-1:0]   tx_full, pndng, rx_empty;
  logic [D*W-1:0] D_pop, rx_data;
  logic [D*8-1:0] drop_cnt;
`ifdef DEST_CHECK_EN
  logic [D*8-1:0] misroute_cnt;
`endif

  bus_dev_fifo_bank #(.drvrs(D), .pckg_sz(W), .depth(DP), .broadcast(8'h8F)) dut (
    .clk(clk), .reset(reset),
    .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full), .pndng(pndng),
    .D_pop(D_pop), .pop(pop), .push(push), .D_push(D_push),
    .rx_rd(rx_rd), .rx_data(rx_data), .rx_empty(rx_empty), .drop_cnt(drop_cnt)
`ifdef DEST_CHECK_EN
    , .misroute_cnt(misroute_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Model state: plain queues and counters.
  logic [W-1:0] txq [D][$];
  logic [W-1:0] rxq [D][$];
  int           drops [D];
  int           mis [D];
  bit           tfull, rfull, td, rd, ok;
  logic [W-1:0] pk;

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%0h want=%0h at %0t", nm, i, act, exp, $time);
    end
  endtask

  initial begin
    for (int i = 0; i < D; i++) begin
      drops[i] = 0;
      mis[i] = 0;
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < D; i++) begin
        txq[i].delete();
        rxq[i].delete();
        drops[i] = 0;
        mis[i] = 0;
      end
    end else begin
      for (int i = 0; i < D; i++) begin
        td = 0;
        rd = 0;
        tfull = (txq[i].size() == DP);
        if (pop[i] && txq[i].size() > 0) void'(txq[i].pop_front());
        if (tx_wr[i]) begin
          if (tfull) td = 1;
          else txq[i].push_back(tx_data[i*W +: W]);
        end
        pk = D_push[i*W +: W];
        ok = 1;
`ifdef DEST_CHECK_EN
        ok = (pk[15:8] == 8'(i)) || (pk[15:8] == 8'h8F);
        if (push[i] && !ok && mis[i] < 255) mis[i]++;
`endif
        rfull = (rxq[i].size() == DP);
        if (rx_rd[i] && rxq[i].size() > 0) void'(rxq[i].pop_front());
        if (push[i] && ok) begin
          if (rfull) rd = 1;
          else rxq[i].push_back(pk);
        end
        drops[i] = drops[i] + int'(td) + int'(rd);
        if (drops[i] > 255) drops[i] = 255;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < D; i++) begin
      chk("pndng", i, 32'(pndng[i]), 32'(txq[i].size() > 0));
      chk("tx_full", i, 32'(tx_full[i]), 32'(txq[i].size() == DP));
      chk("D_pop", i, 32'(D_pop[i*W +: W]), 32'(txq[i].size() > 0 ? txq[i][0] : 16'h0));
      chk("rx_empty", i, 32'(rx_empty[i]), 32'(rxq[i].size() == 0));
      chk("rx_data", i, 32'(rx_data[i*W +: W]), 32'(rxq[i].size() > 0 ? rxq[i][0] : 16'h0));
      chk("drop_cnt", i, 32'(drop_cnt[i*8 +: 8]), 32'(drops[i]));
`ifdef DEST_CHECK_EN
      chk("misroute_cnt", i, 32'(misroute_cnt[i*8 +: 8]), 32'(mis[i]));
`endif
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    tx_wr = '0;
    pop   = '0;
    push  = '0;
    rx_rd = '0;
  endtask

  initial begin
    idle();
    tx_data = '0;
    D_push  = '0;
    repeat (2) tick();
    chk("rst_pndng", 0, 32'(pndng), 32'h0);
    chk("rst_rx_empty", 0, 32'(rx_empty), 32'h1F);
    chk("rst_tx_full", 0, 32'(tx_full), 32'h0);
    reset = 1'b0;
    tick();

    // single write and pop on device 2
    tx_wr[2] = 1'b1;
    tx_data[2*W +: W] = 16'h02AB;
    tick();
    idle();
    chk("t1_pndng", 2, 32'(pndng[2]), 32'h1);
    chk("t1_dpop", 2, 32'(D_pop[2*W +: W]), 32'h02AB);
    pop[2] = 1'b1;
    tick();
    idle();
    chk("t1_pndng_after_pop", 2, 32'(pndng[2]), 32'h0);

    // overfill TX 0 then drain in order
    for (int k = 1; k <= 5; k++) begin
      tx_wr[0] = 1'b1;
      tx_data[0 +: W] = 16'(k);
      tick();
      if (k == 4) chk("t2_full", 0, 32'(tx_full[0]), 32'h1);
    end
    idle();
    chk("t2_drop", 0, 32'(drop_cnt[7:0]), 32'h1);
    for (int k = 1; k <= 4; k++) begin
      chk("t2_order", 0, 32'(D_pop[0 +: W]), 32'(k));
      pop[0] = 1'b1;
      tick();
      idle();
    end
    chk("t2_empty", 0, 32'(pndng[0]), 32'h0);

    // simultaneous write and pop keeps occupancy
    tx_wr[2] = 1'b1;
    tx_data[2*W +: W] = 16'h0201;
    tick();
    tx_data[2*W +: W] = 16'h0202;
    pop[2] = 1'b1;
    tick();
    idle();
    chk("t3_head", 2, 32'(D_pop[2*W +: W]), 32'h0202);
    pop[2] = 1'b1;
    tick();
    idle();

    // pop and read while empty are ignored
    pop = '1;
    rx_rd = '1;
    tick();
    idle();
    chk("t3_empty_drop", 2, 32'(drop_cnt[23:16]), 32'h0);

    // fill RX 4, then push + read together at full
    for (int k = 1; k <= 4; k++) begin
      push[4] = 1'b1;
      D_push[4*W +: W] = 16'h0440 + 16'(k);
      tick();
    end
    D_push[4*W +: W] = 16'h0455;
    rx_rd[4] = 1'b1;
    tick();
    idle();
    chk("t4_drop", 4, 32'(drop_cnt[39:32]), 32'h1);
    chk("t4_head", 4, 32'(rx_data[4*W +: W]), 32'h0442);
    rx_rd[4] = 1'b1;
    repeat (3) tick();
    idle();

`ifdef DEST_CHECK_EN
    push[3] = 1'b1;
    D_push[3*W +: W] = 16'h8F11;
    tick();
    idle();
    chk("t5_stored", 3, 32'(rx_data[3*W +: W]), 32'h8F11);
    push[3] = 1'b1;
    D_push[3*W +: W] = 16'h0111;
    tick();
    idle();
    chk("t5_misroute", 3, 32'(misroute_cnt[31:24]), 32'h1);
    chk("t5_nodrop", 3, 32'(drop_cnt[31:24]), 32'h0);
    rx_rd[3] = 1'b1;
    tick();
    idle();
`endif

    // TX and RX overflow in the same cycle add two
    for (int k = 1; k <= 5; k++) begin
      tx_wr[3] = 1'b1;
      push[3] = 1'b1;
      tx_data[3*W +: W] = 16'h0300 + 16'(k);
      D_push[3*W +: W] = 16'h0310 + 16'(k);
      tick();
    end
    idle();
    chk("t6_double", 3, 32'(drop_cnt[31:24]), 32'h2);

    // saturation of drop counter
    tx_wr[1] = 1'b1;
    tx_data[1*W +: W] = 16'h0100;
    repeat (304) tick();
    idle();
    chk("t7_sat", 1, 32'(drop_cnt[15:8]), 32'hFF);

    // half-fill everything, then asynchronous reset flush
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    for (int k = 0; k < 2; k++) begin
      tx_wr = '1;
      push = '1;
      for (int i = 0; i < D; i++) begin
        tx_data[i*W +: W] = {8'(i), 8'(k + 1)};
        D_push[i*W +: W]  = {8'(i), 8'(k + 8)};
      end
      tick();
    end
    idle();
    chk("t8_half_pndng", 0, 32'(pndng), 32'h1F);
    chk("t8_half_rx", 0, 32'(rx_empty), 32'h0);
    reset = 1'b1;
    #1;
    chk("t8_async_pndng", 0, 32'(pndng), 32'h0);
    chk("t8_async_rx", 0, 32'(rx_empty), 32'h1F);
    tick();
    chk("t8_full", 0, 32'(tx_full), 32'h0);
    chk("t8_drops", 0, drop_cnt[31:0], 32'h0);
    reset = 1'b0;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
